// File: rtl/vTPU_pkg.sv
// Shared VEGETA array constants and the weight-loader state encoding.
package vTPU_pkg;

  localparam int ALPHA          = 1;
  localparam int BETA           = 1;
  localparam int MUL_DATAWIDTH  = 8;
  localparam int META_DATA_SIZE = 2;

  localparam int WGT_W = ALPHA * BETA * (MUL_DATAWIDTH + META_DATA_SIZE);

  typedef enum logic [2:0] {
    WL_IDLE,
    WL_COLLECT,
    WL_FULL,
    WL_SEND,
    WL_DRAIN
  } wl_state_t;

endpackage

// File: rtl/vegeta_wgt_row_buf.sv
// Tile row store: one synchronous write port and one combinational read port.
module vegeta_wgt_row_buf #(
  parameter int X_SCALED = 4,
  parameter int ROW_W    = 40,
  parameter int IDXW     = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDXW-1:0]  i_widx,
  input  logic [ROW_W-1:0] i_wdata,
  input  logic [IDXW-1:0]  i_ridx,
  output logic [ROW_W-1:0] o_rdata
);

  logic [ROW_W-1:0] r_mem [X_SCALED];

  // Pure data storage; every slot is rewritten before a tile is sent.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/vegeta_weight_loader.sv
// Buffers one weight tile from a row stream and shifts it into the systolic
// array top row, deepest row first, then flips the shadow-buffer select.
module vegeta_weight_loader #(
  parameter int X_SCALED = 4,
  parameter int Y_SCALED = 4,
  parameter int WGT_W    = vTPU_pkg::WGT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrow_valid,
  output logic                      wrow_ready,
  input  logic [Y_SCALED*WGT_W-1:0] wrow_data,
  input  logic                      wrow_last,
  input  logic                      send_grant,
  output logic [WGT_W-1:0]          weight_out [0:Y_SCALED-1],
  output logic                      weight_transferring_out,
  output logic                      i_wb,
  output logic                      tile_full,
  output logic                      tile_done,
  output logic                      proto_err
);
  import vTPU_pkg::*;

  localparam int CW    = $clog2(X_SCALED + 1);
  localparam int IDXW  = (X_SCALED > 1) ? $clog2(X_SCALED) : 1;
  localparam int ROW_W = Y_SCALED * WGT_W;
  localparam logic [CW-1:0] LAST = CW'(X_SCALED - 1);

  wl_state_t        r_state;
  wl_state_t        w_next;
  logic [CW-1:0]    r_row_cnt;
  logic [CW-1:0]    r_send_cnt;
  logic [CW-1:0]    r_drain_cnt;
  logic             r_ready;
  logic             r_full;
  logic             r_xfer;
  logic             r_done;
  logic             r_wb;
  logic             r_perr;
  logic [WGT_W-1:0] r_wout [0:Y_SCALED-1];

  logic             w_accept;
  logic             w_last_beat;
  logic             w_done;
  logic [IDXW-1:0]  w_widx;
  logic [IDXW-1:0]  w_ridx;
  logic [ROW_W-1:0] w_rdata;

  // Ready is registered, so only IDLE/COLLECT ever see it high.
  assign w_accept    = wrow_valid & r_ready;
  assign w_last_beat = (r_row_cnt == LAST);
  assign w_widx      = IDXW'(r_row_cnt);
  assign w_ridx      = IDXW'(LAST - r_send_cnt);

  vegeta_wgt_row_buf #(
    .X_SCALED (X_SCALED),
    .ROW_W    (ROW_W),
    .IDXW     (IDXW)
  ) u_row_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_widx  (w_widx),
    .i_wdata (wrow_data),
    .i_ridx  (w_ridx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WL_IDLE;
    else     r_state <= w_next;
  end

  // Bus outputs lag the state by one register, so DRAIN holds X_SCALED state
  // cycles to leave X_SCALED-1 quiet bus cycles before the done pulse.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      WL_IDLE, WL_COLLECT: begin
        if (w_accept) w_next = w_last_beat ? WL_FULL : WL_COLLECT;
      end
      WL_FULL: begin
        if (send_grant) w_next = WL_SEND;
      end
      WL_SEND: begin
        if (r_send_cnt == LAST) w_next = WL_DRAIN;
      end
      WL_DRAIN: begin
        if (r_drain_cnt == LAST) begin
          w_next = WL_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt   <= '0;
      r_send_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) r_row_cnt <= w_last_beat ? '0 : r_row_cnt + 1'b1;
      if (r_state == WL_SEND) r_send_cnt <= r_send_cnt + 1'b1;
      else                    r_send_cnt <= '0;
      if (r_state == WL_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                     r_drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_full  <= 1'b0;
      r_xfer  <= 1'b0;
      r_done  <= 1'b0;
      r_wb    <= 1'b0;
      r_perr  <= 1'b0;
      for (int j = 0; j < Y_SCALED; j++) r_wout[j] <= '0;
    end else begin
      r_ready <= (w_next == WL_IDLE) || (w_next == WL_COLLECT);
      r_full  <= (w_next == WL_FULL);
      r_xfer  <= (r_state == WL_SEND);
      r_done  <= w_done;
      r_wb    <= r_wb ^ w_done;
      r_perr  <= r_perr | (w_accept & (wrow_last != w_last_beat));
      for (int j = 0; j < Y_SCALED; j++)
        r_wout[j] <= (r_state == WL_SEND) ? w_rdata[j*WGT_W +: WGT_W] : '0;
    end
  end

  assign wrow_ready              = r_ready;
  assign tile_full               = r_full;
  assign weight_transferring_out = r_xfer;
  assign tile_done               = r_done;
  assign i_wb                    = r_wb;
  assign proto_err               = r_perr;
  assign weight_out              = r_wout;

endmodule

// File: tb/tb_vegeta_weight_loader.sv
// Directed bench for the weight loader: X_SCALED=4 and X_SCALED=1 builds.
module tb_vegeta_weight_loader;

  localparam int Y = 4;
  localparam int W = vTPU_pkg::WGT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             wrow_valid = 1'b0;
  logic             wrow_last  = 1'b0;
  logic             send_grant = 1'b0;
  logic [Y*W-1:0]   wrow_data  = '0;
  logic             wrow_ready, xfer, i_wb, tile_full, tile_done, proto_err;
  logic [W-1:0]     wout [0:Y-1];

  logic             v1 = 1'b0;
  logic             l1 = 1'b0;
  logic             g1 = 1'b0;
  logic [Y*W-1:0]   d1 = '0;
  logic             rdy1, xfer1, wb1, full1, done1, perr1;
  logic [W-1:0]     wout1 [0:Y-1];

  int n_chk = 0;
  int n_err = 0;
  logic exp_wb = 1'b0;

  vegeta_weight_loader #(.X_SCALED(4), .Y_SCALED(Y), .WGT_W(W)) u_dut (
    .clk(clk), .rst(rst), .wrow_valid(wrow_valid), .wrow_ready(wrow_ready),
    .wrow_data(wrow_data), .wrow_last(wrow_last), .send_grant(send_grant),
    .weight_out(wout), .weight_transferring_out(xfer), .i_wb(i_wb),
    .tile_full(tile_full), .tile_done(tile_done), .proto_err(proto_err)
  );

  vegeta_weight_loader #(.X_SCALED(1), .Y_SCALED(Y), .WGT_W(W)) u_dut1 (
    .clk(clk), .rst(rst), .wrow_valid(v1), .wrow_ready(rdy1),
    .wrow_data(d1), .wrow_last(l1), .send_grant(g1),
    .weight_out(wout1), .weight_transferring_out(xfer1), .i_wb(wb1),
    .tile_full(full1), .tile_done(done1), .proto_err(perr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put_beat(input logic [W-1:0] tag, input logic last);
    int n = 0;
    @(negedge clk);
    wrow_valid = 1'b1;
    wrow_data  = {Y{tag}};
    wrow_last  = last;
    while (!wrow_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready_wait", (n < 50), 1);
    @(posedge clk);
    #1;
    wrow_valid = 1'b0;
    wrow_last  = 1'b0;
  endtask

  task automatic load_tile(input int base, input int gap, input int last_at);
    for (int k = 0; k < 4; k++) begin
      put_beat(W'(base + k), (k == last_at));
      if (gap > 0 && k < 3) repeat (1 + (k % gap)) @(negedge clk);
    end
  endtask

  // Grant after g held-off cycles, then check the bus cycle by cycle.
  task automatic grant_tile(input int base, input int g);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      chk("full_wait", tile_full, 1);
      chk("no_xfer_before_grant", xfer, 0);
      chk("ready_full", wrow_ready, 0);
    end
    @(negedge clk);
    send_grant = 1'b1;
    @(posedge clk);
    #1;
    send_grant = 1'b0;
    @(negedge clk);
    chk("xfer_lat", xfer, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("xfer_on", xfer, 1);
      chk("ready_send", wrow_ready, 0);
      for (int j = 0; j < Y; j++) chk("wout_row", wout[j], 32'(base + 3 - i));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("xfer_off", xfer, 0);
      chk("drain_done", tile_done, 0);
      chk("ready_drain", wrow_ready, 0);
      chk("wout_idle", wout[0], 0);
    end
    @(negedge clk);
    wrow_valid = 1'b0;
    exp_wb = ~exp_wb;
    chk("tile_done", tile_done, 1);
    chk("i_wb_toggle", i_wb, exp_wb);
    chk("ready_idle", wrow_ready, 1);
    @(negedge clk);
    chk("done_pulse", tile_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    // Reset state
    #12;
    chk("rst_ready", wrow_ready, 0);
    chk("rst_xfer", xfer, 0);
    chk("rst_wb", i_wb, 0);
    chk("rst_full", tile_full, 0);
    chk("rst_done", tile_done, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_wout", wout[2], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", wrow_ready, 1);

    // Basic tile
    load_tile(32'hA0, 0, 3);
    grant_tile(32'hA0, 2);
    chk("perr_clean", proto_err, 0);

    // Bubbles and late grant
    load_tile(32'hB0, 3, 3);
    grant_tile(32'hB0, 10);

    // Protocol error: last on beat 1, tile still 4 beats
    load_tile(32'hC0, 0, 1);
    grant_tile(32'hC0, 1);
    chk("perr_set", proto_err, 1);
    load_tile(32'hD0, 1, 3);
    grant_tile(32'hD0, 2);
    chk("perr_sticky", proto_err, 1);

    // Back-pressure: valid held high
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wrow_valid = 1'b1;
      wrow_data  = {Y{W'(32'hE0 + acc)}};
      wrow_last  = (acc == 3);
      if (wrow_ready) acc++;
    end
    chk("bp_accepts", acc, 4);
    chk("bp_full", tile_full, 1);
    grant_tile(32'hE0, 1);
    chk("bp_no_extra", wrow_valid, 0);

    // Reset during the second SEND cycle
    load_tile(32'h60, 0, 3);
    @(negedge clk);
    send_grant = 1'b1;
    @(posedge clk);
    #1;
    send_grant = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_xfer", xfer, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_xfer", xfer, 0);
    chk("arst_wout", wout[0], 0);
    chk("arst_wb", i_wb, 0);
    chk("arst_ready", wrow_ready, 0);
    chk("arst_perr", proto_err, 0);
    chk("arst_full", tile_full, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_wb = 1'b0;
    load_tile(32'h50, 0, 3);
    grant_tile(32'h50, 2);
    chk("reload_perr", proto_err, 0);

    // X_SCALED=1 build
    begin
      int n = 0;
      @(negedge clk);
      v1 = 1'b1;
      d1 = {Y{W'(32'h3C)}};
      l1 = 1'b1;
      while (!rdy1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("x1_ready_wait", (n < 50), 1);
      @(posedge clk);
      #1;
      v1 = 1'b0;
      l1 = 1'b0;
      @(negedge clk);
      chk("x1_full", full1, 1);
      chk("x1_ready_low", rdy1, 0);
      g1 = 1'b1;
      @(posedge clk);
      #1;
      g1 = 1'b0;
      @(negedge clk);
      chk("x1_xfer_lat", xfer1, 0);
      @(negedge clk);
      chk("x1_xfer", xfer1, 1);
      chk("x1_wout", wout1[3], 32'h3C);
      chk("x1_early_done", done1, 0);
      @(negedge clk);
      chk("x1_xfer_off", xfer1, 0);
      chk("x1_done", done1, 1);
      chk("x1_wb", wb1, 1);
      chk("x1_perr", perr1, 0);
      @(negedge clk);
      chk("x1_done_pulse", done1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vegeta_weight_loader.md
# vegeta_weight_loader

Weight-side transmitter for the VEGETA systolic compute array. It accepts one weight tile as X_SCALED row beats on a valid/ready stream and buffers the complete tile. When the controller grants, it streams the tile into the array's top-row `weight_in` ports with `weight_transferring_in` asserted for X_SCALED contiguous cycles, deepest row first. It then waits for the systolic chain to settle, pulses `tile_done`, and flips the `i_wb` shadow-buffer select.

## Interface
Parameters:
- `X_SCALED`, 4: PE rows in the array; equals tile depth in row beats. Must be ≥1.
- `Y_SCALED`, 4: PE columns in the array.
- `WGT_W`, `ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)`: per-PE weight word width, taken from `vTPU_pkg`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: clock.
- `rst`  in  1: async active-high reset.
- `wrow_valid`  in  1: row beat valid.
- `wrow_ready`  out  1: loader can accept a row beat.
- `wrow_data`  in  Y_SCALED*WGT_W: one tile row; column j is at `[j*WGT_W +: WGT_W]`.
- `wrow_last`  in  1: marks beat X_SCALED-1 of the tile.
- `send_grant`  in  1: array shadow buffer is free; streaming may start.
- `weight_out`  out  WGT_W × [0:Y_SCALED-1]: drives the array `weight_in`.
- `weight_transferring_out`  out  1: drives the array `weight_transferring_in`.
- `i_wb`  out  1: shadow-buffer select for the array.
- `tile_full`  out  1: a complete tile is buffered and waiting for grant.
- `tile_done`  out  1: one-cycle pulse when a tile is settled in the array.
- `proto_err`  out  1: sticky flag for a `wrow_last` mismatch.

## Operation
State machine `IDLE → COLLECT → FULL → SEND → DRAIN → IDLE`.
- **IDLE**
  - `wrow_ready`=1; `row_cnt`=0.
  - An accepted beat (valid&ready) writes buffer slot 0 and moves to COLLECT. If X_SCALED=1, it moves directly to FULL.
- **COLLECT**
  - `wrow_ready`=1.
  - Each accepted beat writes slot `row_cnt` and increments `row_cnt`.
  - Acceptance of beat X_SCALED-1 moves to FULL.
  - Bubbles (valid low) are allowed.
- **FULL**
  - `wrow_ready`=0; `tile_full`=1.
  - `send_grant` sampled high moves to SEND with `send_cnt`=0.
- **SEND**
  - Lasts X_SCALED cycles.
  - Each cycle: `weight_transferring_out`=1 and `weight_out[j]` = slot (X_SCALED-1-`send_cnt`), column j. Row X_SCALED-1 goes first so it travels deepest.
  - When `send_cnt` reaches X_SCALED-1, go to DRAIN.
  - `send_grant` is ignored once SEND is entered.
- **DRAIN**
  - Lasts X_SCALED-1 cycles, with `weight_transferring_out`=0.
  - On exit: `tile_done` pulses for 1 cycle and `i_wb` toggles on the same edge; return to IDLE.
  - If X_SCALED=1, DRAIN is 0 cycles: the done/toggle edge is the cycle after the single SEND beat.
- **wrow_last checks**
  - `wrow_last`=1 on any beat other than X_SCALED-1, or `wrow_last`=0 on beat X_SCALED-1, sets `proto_err`.
  - The tile boundary is defined by the count only; `wrow_last` never truncates or extends a tile.
  - `proto_err` clears only on reset.
- **Idle outputs:** outside SEND, `weight_out` is driven to 0 (no stale data on the bus).
- **No overlap:** there is no collection overlap with SEND/DRAIN. Throughput is one tile per ≥ 3·X_SCALED cycles.

## Timing
- All outputs are registered.
- Reset values: `wrow_ready`=0 during reset (1 in IDLE after release); `weight_out`=0; `weight_transferring_out`=0; `i_wb`=0; `tile_full`=0; `tile_done`=0; `proto_err`=0; state IDLE; counters 0.
- Latency:
  - Grant sampled at edge t → `weight_transferring_out` is high for the cycles after edges t+1 … t+X_SCALED.
  - `tile_done` is high in the cycle after edge t+2·X_SCALED.
- Beat k is accepted on the edge where valid&ready are both high. The data is written to the buffer on that edge.
- `wrow_ready` drops in the cycle after the final beat is accepted. Upstream must not rely on a combinational ready.
- Reset asserted mid-operation (any state):
  - All outputs clear asynchronously and the buffered tile is discarded.
  - `i_wb` returns to 0.
  - A partially sent tile is considered lost; the controller must reload it.

## Structure
- Add to `vTPU_pkg`:
  - `localparam WGT_W` = `ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)`.
  - `typedef enum logic [2:0] wl_state_t {WL_IDLE, WL_COLLECT, WL_FULL, WL_SEND, WL_DRAIN}`.
- Counters are `$clog2(X_SCALED+1)` bits wide.
- One sub-module: `vegeta_wgt_row_buf`, an X_SCALED × (Y_SCALED*WGT_W) register file with one write port (index, enable) and one combinational read port (index).
  - The FSM, counters and output registers stay in `vegeta_weight_loader`.

## Test plan
All scenarios use X_SCALED=4 and Y_SCALED=4.
- **Basic tile:** 4 back-to-back beats, rows tagged 0xA0..0xA3 in every column, `wrow_last` on beat 3; grant 2 cycles later.
  - `weight_out` sequence is A3, A2, A1, A0 with transferring high for exactly 4 cycles.
  - `tile_done` pulses 8 cycles after the grant edge; `i_wb` goes 0→1.
- **Bubbles and late grant:** beats separated by 1–3 idle cycles; grant held low for 10 cycles.
  - `tile_full` stays high throughout; no transfer before the grant; output order is identical to the basic tile.
- **Protocol error:** `wrow_last` on beat 1.
  - `proto_err`=1 and stays set; all 4 beats are still collected and sent.
  - A second clean tile still completes, and `i_wb` toggles again (→0).
- **Ready/back-pressure:** `wrow_valid` held high continuously.
  - Exactly 4 beats are accepted.
  - `wrow_ready`=0 from FULL through DRAIN and returns to 1 in IDLE.
- **Reset mid-SEND:** assert `rst` on the 2nd SEND cycle.
  - All outputs go to 0 immediately and `i_wb`=0.
  - After release, a new tile loads and sends correctly.
- **X_SCALED=1 build:** single beat then grant.
  - One transfer cycle; `tile_done` on the next cycle; `i_wb` toggles.
